// File: rtl/glyph_capture_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// glyph_capture_ctrl_pkg
// Shared geometry and state encoding for glyph capture. The display overlay
// uses the same constants for its read mapping and box drawing.
//   WIN_X0/WIN_Y0 : first sampled column/row (inside the drawn box)
//   STEP          : pixel pitch between samples in both axes
//   GLYPH_N       : samples per axis; DEPTH = GLYPH_N*GLYPH_N words/buffer
// ---------------------------------------------------------------------------
package glyph_capture_ctrl_pkg;

   localparam logic [10:0] WIN_X0     = 11'd395;
   localparam logic [9:0]  WIN_Y0     = 10'd315;
   localparam int          STEP       = 3;
   localparam int          GLYPH_N    = 30;
   localparam logic [9:0]  DEPTH      = 10'(GLYPH_N * GLYPH_N);
   // Last value of a phase counter before it wraps and the index advances.
   localparam logic [1:0]  PHASE_LAST = 2'(STEP - 1);
   localparam logic [4:0]  IDX_LAST   = 5'(GLYPH_N - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_SWAP    = 2'd3
   } state_t;

endpackage

// File: rtl/glyph_sampler.sv
// ---------------------------------------------------------------------------
// glyph_sampler
// Tracks the sampling grid over a raster pixel stream with phase/index
// counters and flags the pixels that land on a grid point.
//   clk, rst     : pixel clock, asynchronous active-high reset
//   i_clear      : synchronous clear of all counters (capture (re)start)
//   i_en         : counters advance only while enabled
//   i_pix_valid  : active-video qualifier
//   i_set_x/y    : current pixel coordinates
//   o_hit        : current pixel is a grid sample (combinational)
//   o_addr       : column-major address col*GLYPH_N+row of that sample
// Counting assumes valid pixels of a line arrive with consecutive x. The
// column counters resynchronise on every line at x==WIN_X0 and the row
// counters at (WIN_X0, WIN_Y0), so no divide/modulo is needed.
// ---------------------------------------------------------------------------
module glyph_sampler
   import glyph_capture_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_clear,
   input  logic        i_en,
   input  logic        i_pix_valid,
   input  logic [10:0] i_set_x,
   input  logic [9:0]  i_set_y,
   output logic        o_hit,
   output logic [9:0]  o_addr
);

   logic [1:0] r_col_phase, r_row_phase;
   logic [4:0] r_col_idx, r_row_idx;
   logic       r_col_act, r_row_act;

   logic       w_col_start, w_row_start, w_col_wrap;
   logic [1:0] w_col_phase, w_row_phase;
   logic [4:0] w_col_idx, w_row_idx;
   logic       w_col_act, w_row_act;

   assign w_col_start = i_pix_valid && (i_set_x == WIN_X0);
   assign w_row_start = w_col_start && (i_set_y == WIN_Y0);

   // Column position of the current pixel.
   assign w_col_phase = w_col_start ? 2'd0 : r_col_phase;
   assign w_col_idx   = w_col_start ? 5'd0 : r_col_idx;
   assign w_col_act   = w_col_start | r_col_act;
   assign w_col_wrap  = (w_col_phase == PHASE_LAST);

   // Row position of the current line. It advances once per line, at the
   // line's first window column; the rest of the line uses the stored value.
   always_comb begin
      w_row_phase = r_row_phase;
      w_row_idx   = r_row_idx;
      w_row_act   = r_row_act;
      if (w_row_start) begin
         w_row_phase = 2'd0;
         w_row_idx   = 5'd0;
         w_row_act   = 1'b1;
      end else if (w_col_start && r_row_act) begin
         if (r_row_phase == PHASE_LAST) begin
            w_row_phase = 2'd0;
            if (r_row_idx == IDX_LAST) w_row_act = 1'b0;
            else                       w_row_idx = r_row_idx + 5'd1;
         end else begin
            w_row_phase = r_row_phase + 2'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_col_phase <= 2'd0;
         r_col_idx   <= 5'd0;
         r_col_act   <= 1'b0;
         r_row_phase <= 2'd0;
         r_row_idx   <= 5'd0;
         r_row_act   <= 1'b0;
      end else if (i_clear) begin
         r_col_phase <= 2'd0;
         r_col_idx   <= 5'd0;
         r_col_act   <= 1'b0;
         r_row_phase <= 2'd0;
         r_row_idx   <= 5'd0;
         r_row_act   <= 1'b0;
      end else if (i_en && i_pix_valid) begin
         r_row_phase <= w_row_phase;
         r_row_idx   <= w_row_idx;
         r_row_act   <= w_row_act;
         if (w_col_act) begin
            r_col_phase <= w_col_wrap ? 2'd0 : w_col_phase + 2'd1;
            // Index saturates at the last column; the window then closes.
            r_col_idx   <= (w_col_wrap && (w_col_idx != IDX_LAST)) ?
                           w_col_idx + 5'd1 : w_col_idx;
            r_col_act   <= !(w_col_wrap && (w_col_idx == IDX_LAST));
         end
      end
   end

   assign o_hit  = i_en && i_pix_valid && w_col_act && (w_col_phase == 2'd0)
                   && w_row_act && (w_row_phase == 2'd0);
   assign o_addr = 10'(w_col_idx) * 10'(GLYPH_N) + 10'(w_row_idx);

endmodule

// File: rtl/glyph_capture_ctrl.sv
// ---------------------------------------------------------------------------
// glyph_capture_ctrl
// Captures one GLYPH_N x GLYPH_N digit region from the live pixel stream
// into ping-pong glyph buffers A/B. The display reads buffer disp_sel while
// the writer fills the other one; a completed fill swaps the roles.
//   clk, rst          : pixel clock, asynchronous active-high reset
//   frame_start       : pulse at the first active pixel of a frame
//   pix_valid, set_x, set_y, pix_gray : pixel stream
//   bin_en, thresh    : optional binarisation of written samples
//   capture_req       : request a capture of the next full frame
//   wr_en_a/wr_en_b   : write strobes for buffer A/B (never both)
//   wr_addr, wr_data  : column-major address and sample value
//   disp_sel          : buffer read by the display (0=A, 1=B)
//   busy, done, err   : status; done in the swap cycle, err on truncation
// ---------------------------------------------------------------------------
module glyph_capture_ctrl
   import glyph_capture_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_start,
   input  logic        pix_valid,
   input  logic [10:0] set_x,
   input  logic [9:0]  set_y,
   input  logic [7:0]  pix_gray,
   input  logic        bin_en,
   input  logic [7:0]  thresh,
   input  logic        capture_req,
   output logic        wr_en_a,
   output logic        wr_en_b,
   output logic [9:0]  wr_addr,
   output logic [7:0]  wr_data,
   output logic        disp_sel,
   output logic        busy,
   output logic        done,
   output logic        err
);

   state_t     r_state;
   logic       r_disp_sel, r_wr_en_a, r_wr_en_b, r_busy, r_done, r_err;
   logic       r_pending;
   logic [9:0] r_wr_addr, r_wr_cnt;
   logic [7:0] r_wr_data;

   logic       w_clear, w_en, w_hit;
   logic [9:0] w_addr;
   logic [7:0] w_data;

   // Counters restart on the frame that starts (or restarts) a capture.
   assign w_clear = frame_start && ((r_state == ST_ARMED) || (r_state == ST_CAPTURE));
   assign w_en    = (r_state == ST_CAPTURE);
   assign w_data  = bin_en ? ((pix_gray >= thresh) ? 8'hFF : 8'h00) : pix_gray;

   glyph_sampler u_sampler (
      .clk         (clk),
      .rst         (rst),
      .i_clear     (w_clear),
      .i_en        (w_en),
      .i_pix_valid (pix_valid),
      .i_set_x     (set_x),
      .i_set_y     (set_y),
      .o_hit       (w_hit),
      .o_addr      (w_addr)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_disp_sel <= 1'b0;
         r_wr_en_a  <= 1'b0;
         r_wr_en_b  <= 1'b0;
         r_wr_addr  <= 10'd0;
         r_wr_data  <= 8'd0;
         r_wr_cnt   <= 10'd0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_pending  <= 1'b0;
      end else begin
         r_wr_en_a <= 1'b0;
         r_wr_en_b <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               // A coincident frame_start is ignored; ARMED waits for the next.
               if (capture_req) begin
                  r_state <= ST_ARMED;
                  r_busy  <= 1'b1;
               end
            end
            ST_ARMED: begin
               if (capture_req) r_pending <= 1'b1;
               if (frame_start) begin
                  r_state  <= ST_CAPTURE;
                  r_wr_cnt <= 10'd0;
               end
            end
            ST_CAPTURE: begin
               if (capture_req) r_pending <= 1'b1;
               if (r_wr_cnt == DEPTH) begin
                  r_state    <= ST_SWAP;
                  r_disp_sel <= ~r_disp_sel;
                  r_done     <= 1'b1;
               end else if (frame_start) begin
                  // Truncated fill: the partial buffer is simply never shown.
                  r_err    <= 1'b1;
                  r_wr_cnt <= 10'd0;
               end else if (w_hit) begin
                  r_wr_en_a <= r_disp_sel;
                  r_wr_en_b <= ~r_disp_sel;
                  r_wr_addr <= w_addr;
                  r_wr_data <= w_data;
                  r_wr_cnt  <= r_wr_cnt + 10'd1;
               end
            end
            ST_SWAP: begin
               if (r_pending || capture_req) begin
                  r_state   <= ST_ARMED;
                  r_pending <= 1'b0;
               end else begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign wr_en_a  = r_wr_en_a;
   assign wr_en_b  = r_wr_en_b;
   assign wr_addr  = r_wr_addr;
   assign wr_data  = r_wr_data;
   assign disp_sel = r_disp_sel;
   assign busy     = r_busy;
   assign done     = r_done;
   assign err      = r_err;

endmodule

// File: tb/tb_glyph_capture_ctrl.sv
// ---------------------------------------------------------------------------
// tb_glyph_capture_ctrl
// Drives the pixel rectangle around the sampling window (with occasional
// pix_valid=0 bubbles carrying the same coordinates and a different value).
// Expected writes and done events are queued by the stimulus and checked by
// a monitor on the falling edge.
// ---------------------------------------------------------------------------
module tb_glyph_capture_ctrl;

   typedef struct packed {
      logic       to_a;
      logic [9:0] addr;
      logic [7:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        frame_start, pix_valid, bin_en, capture_req;
   logic [10:0] set_x;
   logic [9:0]  set_y;
   logic [7:0]  pix_gray, thresh;
   logic        wr_en_a, wr_en_b, disp_sel, busy, done, err;
   logic [9:0]  wr_addr;
   logic [7:0]  wr_data;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   last_wr_cyc = -10;
   int   n_wr_a = 0, n_wr_b = 0, n_done = 0, n_err = 0;
   wr_t  exp_q[$];
   logic exp_done_q[$];

   glyph_capture_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .frame_start (frame_start),
      .pix_valid   (pix_valid),
      .set_x       (set_x),
      .set_y       (set_y),
      .pix_gray    (pix_gray),
      .bin_en      (bin_en),
      .thresh      (thresh),
      .capture_req (capture_req),
      .wr_en_a     (wr_en_a),
      .wr_en_b     (wr_en_b),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .disp_sel    (disp_sel),
      .busy        (busy),
      .done        (done),
      .err         (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: one line per write transaction.
   always @(negedge clk) begin
      if (wr_en_a || wr_en_b) begin
         wr_t e;
         chk("single_strobe", int'(wr_en_a && wr_en_b), 0);
         if (exp_q.size() == 0) begin
            chk("unexpected_write", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("wr_buf_a", int'(wr_en_a), int'(e.to_a));
            chk("wr_addr", int'(wr_addr), int'(e.addr));
            chk("wr_data", int'(wr_data), int'(e.data));
         end
         $display("WR buf=%s addr=%0d data=%02h", wr_en_a ? "A" : "B", wr_addr, wr_data);
         last_wr_cyc = cyc;
         if (wr_en_a) n_wr_a++;
         else         n_wr_b++;
      end
      if (done) begin
         n_done++;
         if (exp_done_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            chk("done_disp_sel", int'(disp_sel), int'(exp_done_q.pop_front()));
            chk("done_after_last_wr", cyc, last_wr_cyc + 1);
         end
         $display("DONE disp_sel=%0d", disp_sel);
      end
      if (err) n_err++;
   end

   initial begin
      #(10 * 90000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_fs();
      frame_start = 1'b1;
      pix_valid   = 1'b0;
      step();
      frame_start = 1'b0;
   endtask

   // A few pixels at the window's top-left corner without a frame_start.
   task automatic stub();
      set_y = 10'd315;
      for (int x = 394; x <= 400; x++) begin
         set_x     = 11'(x);
         pix_valid = 1'b1;
         pix_gray  = 8'(x);
         step();
      end
      pix_valid = 1'b0;
   endtask

   // mode 0: gray = x[7:0]; mode 1: samples alternate 7F/80 (binarised 00/FF).
   // max_s != 0 stops right after that many sample pixels.
   task automatic drive_frame(input int max_s, input logic to_a, input int mode,
                              input logic with_reqs);
      int   n;
      int   p;
      logic [7:0] g;
      n = 0;
      p = 0;
      for (int y = 314; y <= 405; y++) begin
         for (int x = 394; x <= 485; x++) begin
            logic q;
            wr_t  e;
            q = (x >= 395) && (x <= 482) && ((x - 395) % 3 == 0) &&
                (y >= 315) && (y <= 402) && ((y - 315) % 3 == 0);
            if (mode == 0) g = 8'(x);
            else           g = (q && (n % 2 == 1)) ? 8'h80 : 8'h7F;
            set_x = 11'(x);
            set_y = 10'(y);
            if ((x + y) % 7 == 0) begin
               pix_valid = 1'b0;
               pix_gray  = ~g;
               step();
            end
            pix_valid   = 1'b1;
            pix_gray    = g;
            capture_req = with_reqs && (p == 100 || p == 2000 || p == 5000);
            if (q) begin
               e.to_a = to_a;
               e.addr = 10'(((x - 395) / 3) * 30 + (y - 315) / 3);
               if (mode == 0) e.data = 8'(x);
               else           e.data = (n % 2 == 1) ? 8'hFF : 8'h00;
               exp_q.push_back(e);
            end
            step();
            capture_req = 1'b0;
            p++;
            if (q) begin
               n++;
               if (max_s != 0 && n == max_s) begin
                  pix_valid = 1'b0;
                  return;
               end
            end
         end
      end
      pix_valid = 1'b0;
   endtask

   task automatic wait_done(input int target);
      for (int i = 0; i < 20 && n_done < target; i++) step();
      chk("done_seen", n_done, target);
   endtask

   initial begin
      rst = 1'b1;
      frame_start = 1'b0; pix_valid = 1'b0; set_x = '0; set_y = '0;
      pix_gray = '0; bin_en = 1'b0; thresh = 8'h80; capture_req = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      step();
      chk("rst_wr_en_a", int'(wr_en_a), 0);
      chk("rst_wr_en_b", int'(wr_en_b), 0);
      chk("rst_wr_addr", int'(wr_addr), 0);
      chk("rst_wr_data", int'(wr_data), 0);
      chk("rst_disp_sel", int'(disp_sel), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_err", int'(err), 0);

      // Request with a coincident frame_start: that frame_start is not used.
      capture_req = 1'b1; frame_start = 1'b1;
      step();
      capture_req = 1'b0; frame_start = 1'b0;
      stub();
      step();
      chk("armed_busy", int'(busy), 1);
      chk("armed_no_writes", n_wr_a + n_wr_b, 0);

      // Capture 1: greyscale into B.
      pulse_fs();
      exp_done_q.push_back(1'b1);
      drive_frame(0, 1'b0, 0, 1'b0);
      wait_done(1);
      repeat (3) step();
      chk("cap1_writes_b", n_wr_b, 900);
      chk("cap1_writes_a", n_wr_a, 0);
      chk("cap1_disp_sel", int'(disp_sel), 1);
      chk("cap1_idle", int'(busy), 0);

      // Capture 2: binarised into A.
      bin_en = 1'b1; thresh = 8'h80;
      capture_req = 1'b1; step(); capture_req = 1'b0;
      pulse_fs();
      exp_done_q.push_back(1'b0);
      drive_frame(0, 1'b1, 1, 1'b0);
      wait_done(2);
      repeat (3) step();
      chk("cap2_writes_a", n_wr_a, 900);
      chk("cap2_writes_b", n_wr_b, 900);
      chk("cap2_disp_sel", int'(disp_sel), 0);

      // Capture 3: truncated after 450 writes, then restarted.
      bin_en = 1'b0;
      capture_req = 1'b1; step(); capture_req = 1'b0;
      pulse_fs();
      drive_frame(450, 1'b0, 0, 1'b0);
      pulse_fs();
      chk("trunc_err", int'(err), 1);
      chk("trunc_disp_sel", int'(disp_sel), 0);
      chk("trunc_busy", int'(busy), 1);
      exp_done_q.push_back(1'b1);
      drive_frame(0, 1'b0, 0, 1'b0);
      wait_done(3);
      repeat (3) step();
      chk("trunc_err_count", n_err, 1);
      chk("cap3_writes_b", n_wr_b, 900 + 1350);
      chk("cap3_disp_sel", int'(disp_sel), 1);

      // Capture 4: three requests during capture merge into one more capture.
      capture_req = 1'b1; step(); capture_req = 1'b0;
      pulse_fs();
      exp_done_q.push_back(1'b0);
      drive_frame(0, 1'b1, 0, 1'b1);
      wait_done(4);
      repeat (3) step();
      chk("pend_armed_busy", int'(busy), 1);
      chk("cap4_writes_a", n_wr_a, 1800);
      pulse_fs();
      exp_done_q.push_back(1'b1);
      drive_frame(0, 1'b0, 0, 1'b0);
      wait_done(5);
      repeat (3) step();
      chk("pend_idle", int'(busy), 0);
      pulse_fs();
      stub();
      step();
      chk("pend_no_extra_writes", n_wr_a + n_wr_b, 1800 + 3150);
      chk("pend_disp_sel", int'(disp_sel), 1);

      // Reset in the middle of a capture into A.
      capture_req = 1'b1; step(); capture_req = 1'b0;
      pulse_fs();
      drive_frame(100, 1'b1, 0, 1'b0);
      #5;
      rst = 1'b1;
      #1;
      chk("mid_rst_wr_en_a", int'(wr_en_a), 0);
      chk("mid_rst_wr_en_b", int'(wr_en_b), 0);
      chk("mid_rst_wr_addr", int'(wr_addr), 0);
      chk("mid_rst_wr_data", int'(wr_data), 0);
      chk("mid_rst_disp_sel", int'(disp_sel), 0);
      chk("mid_rst_busy", int'(busy), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      pulse_fs();
      stub();
      step();
      chk("post_rst_writes", n_wr_a + n_wr_b, 1900 + 3150);
      chk("post_rst_busy", int'(busy), 0);
      chk("exp_queue_empty", exp_q.size(), 0);
      chk("done_queue_empty", exp_done_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/glyph_capture_ctrl.md
Name: glyph_capture_ctrl

Overview:
- Sequences capture of one digit region from the live pixel stream into the two 30x30 8-bit glyph buffers, A and B (900 words each).
- Ping-pong scheme: the display path reads one buffer while this block fills the other. When a fill completes, the roles swap.
- Sits between the pixel-timing generator and the glyph BRAM write ports. The display overlay selects its read buffer from disp_sel.

Parameters:
- WIN_X0, 395, x of the first sampled column (inside the drawn box)
- WIN_Y0, 315, y of the first sampled row
- STEP, 3, pixel pitch between samples in both axes (30 samples span 90 px)
- GLYPH_N, 30, samples per axis
- DEPTH, 900, GLYPH_N*GLYPH_N words per buffer

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle pulse at the first active pixel of a frame
- pix_valid  in  1  active-video qualifier for set_x/set_y/pix_gray
- set_x  in  11  current pixel column
- set_y  in  10  current pixel row
- pix_gray  in  8  current pixel luminance
- bin_en  in  1  1 = binarise written data
- thresh  in  8  binarisation threshold
- capture_req  in  1  one-cycle request to capture the next full frame
- wr_en_a  out  1  write strobe, buffer A
- wr_en_b  out  1  write strobe, buffer B
- wr_addr  out  10  column-major address col*30+row, 0..899
- wr_data  out  8  sample value
- disp_sel  out  1  buffer the display reads (0=A, 1=B); the writer always targets the other buffer
- busy  out  1  high in ARMED, CAPTURE and SWAP
- done  out  1  one-cycle pulse in the SWAP cycle
- err  out  1  one-cycle pulse when a capture is truncated by frame_start

Behaviour:
- Reset (async, any state): state=IDLE; disp_sel=0; all strobes, wr_addr, wr_data, busy, done, err = 0; pending request cleared; counters cleared.
- FSM states: IDLE, ARMED, CAPTURE, SWAP.
- IDLE:
  - capture_req -> ARMED next cycle.
  - A frame_start in the same cycle as capture_req is not consumed; capture begins on the following frame_start.
- ARMED:
  - frame_start -> CAPTURE.
  - Sample counters and the write count are cleared on entry to CAPTURE.
- CAPTURE, sampling condition:
  - pix_valid=1
  - set_x = WIN_X0 + STEP*c and set_y = WIN_Y0 + STEP*r, with c, r in 0..29
  - Implement with phase counters, not divide/modulo.
- CAPTURE, write on each qualifying pixel:
  - Outputs are registered, 1-cycle latency from the qualifying pixel.
  - wr_addr = c*30 + r.
  - wr_data = bin_en ? (pix_gray >= thresh ? 8'hFF : 8'h00) : pix_gray.
  - Strobe: wr_en_b if disp_sel=0, else wr_en_a. Never both; both are 0 outside writes.
- CAPTURE, completion: after the 900th write, go to SWAP on the next cycle without waiting for frame end.
- CAPTURE, truncation: frame_start before 900 writes -> err pulse; written data is discarded (disp_sel unchanged); restart CAPTURE in the same frame, counters cleared.
- SWAP (exactly 1 cycle): disp_sel toggles, done=1. Next state is ARMED if a request is pending, else IDLE.
- capture_req during ARMED, CAPTURE or SWAP sets a one-deep pending flag. Further requests merge into it. The flag clears on entering ARMED from SWAP.
- Widths: c*30+r is computed in 10 bits, max 899, so there is no wrap. The phase counters are 2 bits and the index counters 5 bits, saturating at 29.
- pix_valid=0 pixels are never sampled, even when the coordinates match.

Decomposition:
- Shared package: WIN_X0, WIN_Y0, STEP, GLYPH_N, DEPTH, FSM state encoding. These are also used by the display overlay for its read mapping and box geometry.
- One sub-module, glyph_sampler: phase/index counters plus the sample-qualify and address generation. The parent keeps the FSM, ping-pong and pending logic.

Test Plan:
- Reset, then capture_req, then one 1280x720 frame with pix_gray=set_x[7:0] and bin_en=0:
  - exactly 900 wr_en_b pulses, first at addr 0 with data 8'h8B (395), last at addr 899;
  - done and the disp_sel 0->1 toggle occur in the same cycle, 1 cycle after the last write.
- Second capture_req: writes go to wr_en_a only; after done, disp_sel=0.
- bin_en=1, thresh=8'h80, pix_gray alternating 8'h7F/8'h80 per sample: wr_data alternates 8'h00/8'hFF.
- frame_start injected after 450 writes: err pulses once, disp_sel unchanged, capture restarts and finishes with 900 writes in that frame.
- capture_req pulsed three times during CAPTURE: after done, the block goes straight to ARMED and performs exactly one further capture.
- rst asserted mid-CAPTURE: all outputs go to 0 immediately, disp_sel=0, state IDLE; no writes until a new capture_req plus frame_start.
